// File: rtl/piano_pkg.sv
// Shared definitions for the piano keyboard front end: key count, one-hot
// note codes (shared with the segment decoder) and the selector state type.
package piano_pkg;

  localparam int NUM_KEYS = 5;

  localparam logic [NUM_KEYS-1:0] NOTE_OFF = 5'b00000;
  localparam logic [NUM_KEYS-1:0] NOTE_C   = 5'b00001;
  localparam logic [NUM_KEYS-1:0] NOTE_D   = 5'b00010;
  localparam logic [NUM_KEYS-1:0] NOTE_E   = 5'b00100;
  localparam logic [NUM_KEYS-1:0] NOTE_F   = 5'b01000;
  localparam logic [NUM_KEYS-1:0] NOTE_G   = 5'b10000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } sel_state_t;

  // Isolates the lowest set bit, so the result is always one-hot or zero.
  function automatic logic [NUM_KEYS-1:0] lowest_bit(input logic [NUM_KEYS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/note_key_scanner_if.sv
// Note bus from the key scanner to the note-letter segment decoder.
interface note_key_scanner_if;
  import piano_pkg::*;

  logic [NUM_KEYS-1:0] note_onehot;
  logic                note_valid;
  logic                note_change;
  logic [NUM_KEYS-1:0] key_stable;

  modport master (output note_onehot, note_valid, note_change, key_stable);
  modport slave  (input  note_onehot, note_valid, note_change, key_stable);

endinterface

// File: rtl/note_key_scanner_key_debounce.sv
// One push-button: 2-flop synchronizer followed by a restart-on-glitch
// debounce counter that accepts a new level after DEBOUNCE_CYCLES samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta_reg;
  logic          key_sync_reg;
  logic [CW-1:0] count_reg;
  logic          stable_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      key_sync_reg  <= 1'b0;
      count_reg     <= '0;
      stable_reg    <= 1'b0;
    end else begin
      sync_meta_reg <= key_raw;
      key_sync_reg  <= sync_meta_reg;
      if (key_sync_reg != stable_reg) begin
        // Terminal count is reached before any wrap could happen.
        if (count_reg == CNT_LAST) begin
          stable_reg <= key_sync_reg;
          count_reg  <= '0;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end else begin
        count_reg <= '0;
      end
    end
  end

  assign key_stable = stable_reg;

endmodule

// File: rtl/note_key_scanner.sv
// Five debounced piano keys feeding a last-pressed-wins selector that drives
// a one-hot (or OFF) note code toward the segment decoder.
module note_key_scanner
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  note_key_scanner_if.master  notes
);

  logic [NUM_KEYS-1:0] key_stable;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (key_raw[gi]),
        .key_stable(key_stable[gi])
      );
    end
  endgenerate

  sel_state_t          state_reg, state_next;
  logic [NUM_KEYS-1:0] stable_prev_reg;
  logic [NUM_KEYS-1:0] note_reg, note_next;
  logic                valid_reg;
  logic                change_reg;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_ev;

  assign press      = key_stable & ~stable_prev_reg;
  assign release_ev = ~key_stable & stable_prev_reg;

  // Presses take priority over any release in the same cycle.
  always_comb begin
    state_next = state_reg;
    note_next  = note_reg;
    if (|press) begin
      state_next = PLAY;
      note_next  = lowest_bit(press);
    end else if (state_reg == PLAY && |(release_ev & note_reg)) begin
      if (|key_stable) begin
        note_next = lowest_bit(key_stable);
      end else begin
        state_next = IDLE;
        note_next  = NOTE_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      stable_prev_reg <= '0;
      note_reg        <= NOTE_OFF;
      valid_reg       <= 1'b0;
      change_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stable_prev_reg <= key_stable;
      note_reg        <= note_next;
      valid_reg       <= |note_next;
      change_reg      <= (note_next != note_reg);
    end
  end

  assign notes.note_onehot = note_reg;
  assign notes.note_valid  = valid_reg;
  assign notes.note_change = change_reg;
  assign notes.key_stable  = key_stable;

endmodule

// File: tb/tb_note_key_scanner.sv
// Directed and random checks of the key scanner with DEBOUNCE_CYCLES = 4.
module tb_note_key_scanner;
  import piano_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_raw = 5'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  note_key_scanner_if notes ();

  note_key_scanner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .key_raw(key_raw),
    .notes  (notes.master)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] note, input logic chg);
    check({tag, ".note"},   32'(notes.note_onehot), 32'(note));
    check({tag, ".valid"},  32'(notes.note_valid),  32'(|note));
    check({tag, ".change"}, 32'(notes.note_change), 32'(chg));
  endtask

  initial begin
    logic [4:0] prev_note;
    int         hold;

    // Reset state
    tick(2);
    check_outs("reset", NOTE_OFF, 1'b0);
    check("reset.stable", 32'(notes.key_stable), 32'h0);
    reset = 1'b0;
    tick(1);

    // 1. Clean press of E: stable at edge 6, note at edge 7
    $display("step: clean press E");
    key_raw = 5'b00100;
    tick(6);
    check("press_e.stable6", 32'(notes.key_stable), 32'(NOTE_E));
    check_outs("press_e.e6", NOTE_OFF, 1'b0);
    tick(1);
    check_outs("press_e.e7", NOTE_E, 1'b1);
    tick(1);
    check_outs("press_e.e8", NOTE_E, 1'b0);
    key_raw = 5'b00000;
    tick(6);
    check_outs("rel_e.e6", NOTE_E, 1'b0);
    tick(1);
    check_outs("rel_e.e7", NOTE_OFF, 1'b1);
    tick(1);
    check_outs("rel_e.e8", NOTE_OFF, 1'b0);

    // 2. Bounce rejection: 3 high / 1 low never completes 4 stable samples
    $display("step: bounce rejection on C");
    for (int i = 0; i < 10; i++) begin
      key_raw = 5'b00001;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        check("bounce.stable", 32'(notes.key_stable), 32'h0);
        check_outs("bounce", NOTE_OFF, 1'b0);
      end
      key_raw = 5'b00000;
      tick(1);
      check("bounce.stable", 32'(notes.key_stable), 32'h0);
      check_outs("bounce", NOTE_OFF, 1'b0);
    end
    tick(10);
    check("bounce.stable_end", 32'(notes.key_stable), 32'h0);
    check_outs("bounce.end", NOTE_OFF, 1'b0);

    // 3. Last-pressed-wins and fallback to lowest held key
    $display("step: last-pressed-wins C then D");
    key_raw = 5'b00001;
    tick(7);
    check_outs("lpw.c", NOTE_C, 1'b1);
    key_raw = 5'b00011;
    tick(7);
    check_outs("lpw.d", NOTE_D, 1'b1);
    tick(1);
    key_raw = 5'b00001;
    tick(6);
    check_outs("lpw.d_held", NOTE_D, 1'b0);
    tick(1);
    check_outs("lpw.back_c", NOTE_C, 1'b1);
    tick(1);
    check_outs("lpw.back_c2", NOTE_C, 1'b0);
    key_raw = 5'b00000;
    tick(7);
    check_outs("lpw.off", NOTE_OFF, 1'b1);

    // 4. Simultaneous press of F and G: lowest index wins
    $display("step: simultaneous F+G");
    tick(2);
    key_raw = 5'b11000;
    tick(6);
    check("simul.stable", 32'(notes.key_stable), 32'h18);
    check_outs("simul.e6", NOTE_OFF, 1'b0);
    tick(1);
    check_outs("simul.e7", NOTE_F, 1'b1);
    key_raw = 5'b00000;
    tick(8);
    check_outs("simul.off", NOTE_OFF, 1'b0);

    // 5. Reset while G plays and D is mid-count
    $display("step: reset mid-operation");
    key_raw = 5'b10000;
    tick(7);
    check_outs("rst.g", NOTE_G, 1'b1);
    tick(2);
    key_raw = 5'b10010;
    tick(4);
    reset = 1'b1;
    tick(1);
    check_outs("rst.cleared", NOTE_OFF, 1'b0);
    check("rst.stable", 32'(notes.key_stable), 32'h0);
    reset = 1'b0;
    tick(1);
    check_outs("rst.after1", NOTE_OFF, 1'b0);
    tick(4);
    check("rst.stable5", 32'(notes.key_stable), 32'h0);
    tick(1);
    check("rst.stable6", 32'(notes.key_stable), 32'h12);
    check_outs("rst.e6", NOTE_OFF, 1'b0);
    tick(1);
    check_outs("rst.e7", NOTE_D, 1'b1);
    key_raw = 5'b00000;
    tick(8);
    check_outs("rst.off", NOTE_OFF, 1'b0);

    // 6. Random stress: one-hot, valid and change consistency every cycle
    $display("step: random stress");
    prev_note = notes.note_onehot;
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold == 0) begin
        key_raw = 5'($urandom_range(0, 31));
        hold = $urandom_range(1, 10);
      end
      hold--;
      tick(1);
      check("rand.onehot0", 32'($onehot0(notes.note_onehot)), 32'h1);
      check("rand.valid", 32'(notes.note_valid), 32'(|notes.note_onehot));
      check("rand.change", 32'(notes.note_change), 32'(notes.note_onehot != prev_note));
      prev_note = notes.note_onehot;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
